// File: rtl/shader_result_pkg.sv
// rtl/shader_result_pkg.sv - shared types and helpers for the shader result collector
package shader_result_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int LANES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        SCALAR,
        LANE
    } ser_state_e;

    typedef struct packed {
        logic [WIDTH_DEF-1:0]           scalar;
        logic [WIDTH_DEF*LANES_DEF-1:0] vector;
    } result_t;

    // A single-lane build still needs a 1-bit lane index port.
    function automatic int lane_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/shader_result_fifo.sv
// rtl/shader_result_fifo.sv - synchronous FIFO of shader results
module shader_result_fifo
    import shader_result_pkg::*;
#(
    parameter type entry_t = result_t,
    parameter int  DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  entry_t                 wdata,
    input  logic                   pop,
    output entry_t                 rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage is not reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/shader_result_collector.sv
// rtl/shader_result_collector.sv - buffers shader results and serializes them into writeback beats
module shader_result_collector
    import shader_result_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LANES = LANES_DEF,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid,
    output logic                       ready,
    input  logic [WIDTH-1:0]           result_s,
    input  logic [WIDTH*LANES-1:0]     result_v,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [WIDTH-1:0]           wb_data,
    output logic                       wb_is_scalar,
    output logic [lane_w(LANES)-1:0]   wb_lane,
    output logic                       wb_last,
    output logic [CNT_W-1:0]           result_cnt,
    output logic                       busy
);

    localparam int LANE_W = lane_w(LANES);
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef struct packed {
        logic [WIDTH-1:0]       scalar;
        logic [WIDTH*LANES-1:0] vector;
    } entry_t;

    ser_state_e                   state_q, state_d;
    logic [LANE_W-1:0]            lane_q, lane_d;
    entry_t                       hold_q, hold_d;
    entry_t                       wdata, head;
    logic                         ready_q, ready_d;
    logic [CNT_W-1:0]             cnt_q;
    logic                         push, pop;
    logic                         fifo_full, fifo_empty;
    logic [CW-1:0]                fifo_count, count_next;
    logic [LANES-1:0][WIDTH-1:0]  lanes_d;

    logic                         wb_valid_q, wb_valid_d;
    logic [WIDTH-1:0]             wb_data_q, wb_data_d;
    logic                         wb_is_scalar_q, wb_is_scalar_d;
    logic [LANE_W-1:0]            wb_lane_q, wb_lane_d;
    logic                         wb_last_q, wb_last_d;

    assign wdata.scalar = result_s;
    assign wdata.vector = result_v;
    assign push         = valid && ready_q && !fifo_full;

    shader_result_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        hold_d  = hold_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    hold_d  = head;
                    pop     = 1'b1;
                    state_d = SCALAR;
                end
            end
            SCALAR: begin
                if (wb_ready) begin
                    lane_d  = '0;
                    state_d = LANE;
                end
            end
            LANE: begin
                if (wb_ready) begin
                    if (lane_q != LAST_LANE) begin
                        lane_d = lane_q + 1'b1;
                    end else if (!fifo_empty) begin
                        // Reload straight from the last lane so results stream without a bubble.
                        hold_d  = head;
                        pop     = 1'b1;
                        state_d = SCALAR;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign lanes_d = hold_d.vector;

    // Beat outputs are derived from the next state so they can be registered.
    always_comb begin
        wb_valid_d     = (state_d != IDLE);
        wb_is_scalar_d = (state_d == SCALAR);
        wb_lane_d      = '0;
        wb_last_d      = 1'b0;
        wb_data_d      = '0;
        if (state_d == SCALAR) begin
            wb_data_d = hold_d.scalar;
        end else if (state_d == LANE) begin
            wb_lane_d = lane_d;
            wb_last_d = (lane_d == LAST_LANE);
            wb_data_d = lanes_d[lane_d];
        end
    end

    assign count_next = fifo_count + CW'(push) - CW'(pop);
    assign ready_d    = (count_next < CW'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            lane_q         <= '0;
            hold_q         <= '0;
            ready_q        <= 1'b0;
            cnt_q          <= '0;
            wb_valid_q     <= 1'b0;
            wb_data_q      <= '0;
            wb_is_scalar_q <= 1'b0;
            wb_lane_q      <= '0;
            wb_last_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            lane_q         <= lane_d;
            hold_q         <= hold_d;
            ready_q        <= ready_d;
            wb_valid_q     <= wb_valid_d;
            wb_data_q      <= wb_data_d;
            wb_is_scalar_q <= wb_is_scalar_d;
            wb_lane_q      <= wb_lane_d;
            wb_last_q      <= wb_last_d;
            if (push) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign ready        = ready_q;
    assign wb_valid     = wb_valid_q;
    assign wb_data      = wb_data_q;
    assign wb_is_scalar = wb_is_scalar_q;
    assign wb_lane      = wb_lane_q;
    assign wb_last      = wb_last_q;
    assign result_cnt   = cnt_q;
    assign busy         = (fifo_count != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_shader_result_collector.sv
// tb/tb_shader_result_collector.sv - directed self-checking bench for shader_result_collector
module tb_shader_result_collector;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid;
    logic         ready;
    logic [31:0]  result_s;
    logic [127:0] result_v;
    logic         wb_valid;
    logic         wb_ready;
    logic [31:0]  wb_data;
    logic         wb_is_scalar;
    logic [1:0]   wb_lane;
    logic         wb_last;
    logic [3:0]   result_cnt;
    logic         busy;

    int           n_cmp = 0;
    int           n_bad = 0;
    int           n_acc = 0;
    logic [3:0]   exp_cnt = '0;
    logic [35:0]  exp_q [$];
    logic         prev_stall = 1'b0;
    logic [36:0]  prev_out = '0;

    always #5 clk = ~clk;

    shader_result_collector #(
        .WIDTH (32),
        .LANES (4),
        .DEPTH (4),
        .CNT_W (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid        (valid),
        .ready        (ready),
        .result_s     (result_s),
        .result_v     (result_v),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_data      (wb_data),
        .wb_is_scalar (wb_is_scalar),
        .wb_lane      (wb_lane),
        .wb_last      (wb_last),
        .result_cnt   (result_cnt),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_result(input logic [31:0] s, input logic [127:0] v);
        exp_q.push_back({s, 1'b1, 2'd0, 1'b0});
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({v[i*32 +: 32], 1'b0, 2'(i), (i == 3)});
        end
    endtask

    task automatic set_payload(input int seq);
        result_s = 32'h5000_0000 + 32'(seq);
        for (int i = 0; i < 4; i++) begin
            result_v[i*32 +: 32] = 32'hC000_0000 + (32'(seq) << 4) + 32'(i);
        end
    endtask

    // One clock; records an accept seen at this edge in the expected stream.
    task automatic cycle();
        logic acc;
        logic [31:0]  s;
        logic [127:0] v;
        acc = valid && ready;
        s   = result_s;
        v   = result_v;
        @(posedge clk);
        #1;
        if (acc) begin
            n_acc++;
            exp_cnt++;
            expect_result(s, v);
        end
    endtask

    task automatic drain(input string tag, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (exp_q.size() == 0) break;
            cycle();
        end
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard and hold-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        logic [36:0] cur;
        logic [35:0] e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            cur = {wb_valid, wb_data, wb_is_scalar, wb_lane, wb_last};
            if (prev_stall) check("hold_stable", 64'(cur), 64'(prev_out));
            if (wb_valid && wb_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 64'(cur[35:0]), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 64'(cur[35:0]), 64'(e));
                end
            end
            prev_stall = wb_valid && !wb_ready;
            prev_out   = cur;
        end
    end

    initial begin
        int n0;
        int beats;
        int gaps;
        int pushed;

        rst_n    = 1'b0;
        valid    = 1'b0;
        wb_ready = 1'b0;
        result_s = '0;
        result_v = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_wb", 64'({wb_valid, wb_data, wb_is_scalar, wb_lane, wb_last}), 64'd0);
        check("rst_cnt_busy", 64'({result_cnt, busy}), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rel_ready_pre", 64'(ready), 64'd0);
        @(posedge clk);
        #1;
        check("rel_ready_post", 64'(ready), 64'd1);

        // Single result with fixed payload and constant expected beats.
        wb_ready = 1'b1;
        result_s = 32'hA5A5_0001;
        result_v = {32'h4, 32'h3, 32'h2, 32'h1};
        exp_q.push_back({32'hA5A5_0001, 1'b1, 2'd0, 1'b0});
        exp_q.push_back({32'h1, 1'b0, 2'd0, 1'b0});
        exp_q.push_back({32'h2, 1'b0, 2'd1, 1'b0});
        exp_q.push_back({32'h3, 1'b0, 2'd2, 1'b0});
        exp_q.push_back({32'h4, 1'b0, 2'd3, 1'b1});
        valid = 1'b1;
        check("t1_ready", 64'(ready), 64'd1);
        @(posedge clk);
        #1;
        exp_cnt++;
        n_acc++;
        valid = 1'b0;
        check("t1_no_bypass", 64'(wb_valid), 64'd0);
        cycle();
        check("t1_first_beat", 64'({wb_valid, wb_is_scalar, wb_data}), {31'd0, 1'b1, 1'b1, 32'hA5A5_0001});
        check("t1_busy", 64'(busy), 64'd1);
        drain("t1_drain", 20);
        check("t1_cnt", 64'(result_cnt), 64'd1);
        check("t1_idle", 64'({busy, wb_valid}), 64'd0);

        // Three back-to-back results: 15 gap-free beats.
        beats = 0;
        gaps  = 0;
        for (int k = 0; k < 30; k++) begin
            valid = (k < 3);
            set_payload(k + 1);
            if (k < 3) check("b2b_ready", 64'(ready), 64'd1);
            if (wb_valid) beats++;
            else if (beats > 0 && beats < 15) gaps++;
            cycle();
        end
        valid = 1'b0;
        check("b2b_beats", 64'(beats), 64'd15);
        check("b2b_gaps", 64'(gaps), 64'd0);
        check("b2b_drain", 64'(exp_q.size()), 64'd0);
        check("b2b_cnt", 64'(result_cnt), 64'(exp_cnt));

        // Backpressure: 4 queued plus 1 held before ready drops.
        wb_ready = 1'b0;
        valid    = 1'b1;
        n0       = n_acc;
        for (int k = 0; k < 12; k++) begin
            set_payload(100 + n_acc);
            cycle();
        end
        check("bp_accepts", 64'(n_acc - n0), 64'd5);
        check("bp_ready_low", 64'(ready), 64'd0);
        wb_ready = 1'b1;
        cycle();
        wb_ready = 1'b0;
        cycle();
        check("bp_scalar_no_free", 64'(ready), 64'd0);
        wb_ready = 1'b1;
        repeat (3) cycle();
        check("bp_lanes_no_free", 64'(ready), 64'd0);
        cycle();
        check("bp_rerise", 64'(ready), 64'd1);
        cycle();
        valid = 1'b0;
        drain("bp_drain", 60);
        check("bp_cnt", 64'(result_cnt), 64'(exp_cnt));

        // wb_ready toggling every cycle.
        pushed = 0;
        n0     = n_acc;
        for (int k = 0; k < 40; k++) begin
            wb_ready = k[0];
            valid    = (n_acc - n0) < 2;
            set_payload(200 + n_acc);
            cycle();
        end
        valid = 1'b0;
        check("tog_accepts", 64'(n_acc - n0), 64'd2);
        wb_ready = 1'b1;
        drain("tog_drain", 20);

        // Reset after lane1 handshake.
        set_payload(300);
        valid = 1'b1;
        cycle();
        valid = 1'b0;
        repeat (4) cycle();
        check("mid_left", 64'(exp_q.size()), 64'd2);
        rst_n = 1'b0;
        #1;
        check("mid_wb", 64'({wb_valid, wb_data, wb_is_scalar, wb_lane, wb_last}), 64'd0);
        check("mid_ready_cnt_busy", 64'({ready, result_cnt, busy}), 64'd0);
        exp_q.delete();
        exp_cnt = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("mid_rel_ready_pre", 64'(ready), 64'd0);
        @(posedge clk);
        #1;
        check("mid_rel_ready_post", 64'(ready), 64'd1);
        check("mid_rel_cnt", 64'(result_cnt), 64'd0);

        // Counter wrap at CNT_W=4: 17 accepts read back as 1.
        n0    = n_acc;
        valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (n_acc - n0 >= 17) break;
            set_payload(400 + n_acc);
            cycle();
        end
        valid = 1'b0;
        check("wrap_accepts", 64'(n_acc - n0), 64'd17);
        drain("wrap_drain", 120);
        check("wrap_cnt", 64'(result_cnt), 64'd1);
        check("wrap_idle", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
